// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute/writeback controller
// with fetch timeout, illegal-opcode fault and a saturating retire counter.
module cpu_sequencer #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        ck,
    input  logic        res_n,
    input  logic        start,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic [15:0] inst,
    output logic        dec_en,
    output logic        rf_we,
    output logic [7:0]  pc,
    output logic        busy,
    output logic        halted,
    output logic        fault,
    output logic [15:0] retired
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALTED} state_t;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_XOR   = 4'h4;
    localparam logic [3:0] OP_LOADI = 4'h5;
    localparam logic [3:0] OP_JMP   = 4'h6;
    localparam logic [3:0] OP_HALT  = 4'h7;
    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] inst_q, inst_d;
    logic [15:0] retired_q, retired_d;
    logic        fault_q, fault_d;
    logic [CW-1:0] wait_q, wait_d;
    logic        retire;
    logic [3:0]  op;

    assign op = inst_q[15:12];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        fault_d = fault_q;
        wait_d  = '0;
        retire  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = FETCH;
                pc_d    = '0;
            end
            FETCH: if (imem_ack) begin
                inst_d  = imem_data;
                pc_d    = pc_q + 8'd1;
                state_d = DECODE;
            end else if (wait_q == CW'(ACK_TIMEOUT - 1)) begin
                fault_d = 1'b1;
                state_d = HALTED;
            end else begin
                wait_d = wait_q + 1'b1;
            end
            DECODE: state_d = EXEC;
            EXEC: if (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LOADI}) begin
                state_d = WB;
            end else if (op == OP_JMP) begin
                pc_d    = inst_q[7:0];
                retire  = 1'b1;
                state_d = FETCH;
            end else if (op == OP_HALT) begin
                retire  = 1'b1;
                state_d = HALTED;
            end else begin
                fault_d = 1'b1;
                state_d = FETCH;
            end
            WB: begin
                retire  = 1'b1;
                state_d = FETCH;
            end
            default: ;
        endcase
        retired_d = (retire && retired_q != 16'hFFFF) ? retired_q + 16'd1 : retired_q;
    end

    always_ff @(posedge ck) begin
        if (!res_n) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            inst_q    <= '0;
            retired_q <= '0;
            fault_q   <= 1'b0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            retired_q <= retired_d;
            fault_q   <= fault_d;
            wait_q    <= wait_d;
        end
    end

    // every output is a decode of registered state only
    assign imem_req  = state_q == FETCH;
    assign imem_addr = pc_q;
    assign dec_en    = state_q == DECODE;
    assign rf_we     = state_q == WB;
    assign busy      = state_q != IDLE && state_q != HALTED;
    assign halted    = state_q == HALTED;
    assign pc        = pc_q;
    assign inst      = inst_q;
    assign fault     = fault_q;
    assign retired   = retired_q;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: table vectors, hand sequences and randomized programs
// checked against an instruction-level model of the sequencer.
module tb_cpu_sequencer;
    localparam int ACK_T = 16;

    logic        ck = 1'b0;
    logic        res_n, start, imem_ack;
    logic [15:0] imem_data;
    logic        imem_req, dec_en, rf_we, busy, halted, fault;
    logic [7:0]  imem_addr, pc;
    logic [15:0] inst, retired;

    cpu_sequencer #(.ACK_TIMEOUT(ACK_T)) dut (
        .ck(ck), .res_n(res_n), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .inst(inst), .dec_en(dec_en), .rf_we(rf_we), .pc(pc),
        .busy(busy), .halted(halted), .fault(fault), .retired(retired)
    );

    always #5 ck = ~ck;

    typedef struct {
        logic [15:0] m0, m1;
        int          d0, n, a1;
        logic [15:0] ret;
        logic        flt;
        logic [7:0]  pc;
        int          we;
    } vec_t;

    logic [15:0] mem [256];
    int          dly [256];
    int          got_addr[$], got_cyc[$], exp_addr[$], exp_cyc[$];
    logic [15:0] dec_inst[$];
    logic [2:0]  trace[$];
    int          got_we, exp_we, exp_ret;
    bit          excl_bad, exp_flt, exp_halt;
    logic [7:0]  exp_pc;
    int          n_tests = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    task automatic load_default();
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'h7000;
            dly[i] = 0;
        end
    endtask

    // drives reset+start, then plays memory until halted, fetch cap or cycle budget
    task automatic run(input int max_fetch, input bit noise);
        int w, k;
        w = 0; k = 0; got_we = 0; excl_bad = 0;
        got_addr.delete(); got_cyc.delete(); dec_inst.delete(); trace.delete();
        res_n = 1'b0; start = 1'b0; imem_ack = 1'b0; imem_data = '0;
        repeat (2) @(negedge ck);
        res_n = 1'b1; start = 1'b1;
        @(negedge ck);
        start = 1'b0;
        for (int c = 0; c < 3000 && !halted && k < max_fetch; c++) begin
            trace.push_back({imem_req, dec_en, rf_we});
            if (int'(imem_req) + int'(dec_en) + int'(rf_we) > 1) excl_bad = 1'b1;
            if (rf_we) got_we++;
            if (dec_en) dec_inst.push_back(inst);
            if (imem_req && w >= dly[k]) begin
                imem_ack = 1'b1;
                imem_data = mem[imem_addr];
                got_addr.push_back(int'(imem_addr));
                got_cyc.push_back(c);
                k++;
                w = 0;
            end else begin
                imem_ack = (noise && !imem_req) ? 1'($urandom) : 1'b0;
                imem_data = 16'($urandom);
                if (imem_req) w++;
            end
            start = (noise && busy) ? 1'($urandom) : 1'b0;
            @(negedge ck);
        end
        imem_ack = 1'b0;
        start = 1'b0;
    endtask

    // instruction-level interpreter: fetch times from per-fetch delays and op latencies
    task automatic model(input int max_fetch);
        logic [7:0]  p;
        logic [15:0] ins;
        int t, a, n;
        p = '0; t = 0; n = 0;
        exp_ret = 0; exp_we = 0; exp_flt = 0; exp_halt = 0;
        exp_addr.delete(); exp_cyc.delete();
        while (n < max_fetch && !exp_halt) begin
            if (dly[n] >= ACK_T) begin
                exp_flt = 1;
                exp_halt = 1;
            end else begin
                a = t + dly[n];
                exp_addr.push_back(int'(p));
                exp_cyc.push_back(a);
                ins = mem[p];
                p = p + 8'd1;
                n++;
                if (ins[15:12] <= 4'd5) begin
                    exp_we++; exp_ret++; t = a + 4;
                end else if (ins[15:12] == 4'd6) begin
                    p = ins[7:0]; exp_ret++; t = a + 3;
                end else if (ins[15:12] == 4'd7) begin
                    exp_ret++; exp_halt = 1;
                end else begin
                    exp_flt = 1; t = a + 3;
                end
            end
        end
        exp_pc = p;
    endtask

    task automatic check_model();
        chk("n_fetch", got_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            chk("fetch_addr", got_addr[i], exp_addr[i]);
            chk("fetch_cycle", got_cyc[i], exp_cyc[i]);
        end
        chk("strobe_exclusive", excl_bad, 0);
        if (exp_halt) begin
            chk("halted", {halted, busy}, 2'b10);
            chk("retired", retired, exp_ret);
            chk("fault", fault, exp_flt);
            chk("pc", pc, exp_pc);
            chk("rf_we_count", got_we, exp_we);
        end
    endtask

    task automatic halt_start();
        start = 1'b1;
        repeat (3) @(negedge ck);
        start = 1'b0;
        chk("halt_sticky", {halted, busy, imem_req}, 3'b100);
    endtask

    initial begin
        vec_t tbl [9];
        logic [2:0] exp_tr [5];
        logic [15:0] ins;
        tbl[0] = '{16'h5105, 16'h7000, 0,     2, 1,  16'd2, 1'b0, 8'd2,  1};
        tbl[1] = '{16'h0123, 16'h7000, 0,     2, 1,  16'd2, 1'b0, 8'd2,  1};
        tbl[2] = '{16'h4abc, 16'h7000, 0,     2, 1,  16'd2, 1'b0, 8'd2,  1};
        tbl[3] = '{16'h6010, 16'h7000, 0,     2, 16, 16'd2, 1'b0, 8'h11, 0};
        tbl[4] = '{16'h7000, 16'h7000, 0,     1, 0,  16'd1, 1'b0, 8'd1,  0};
        tbl[5] = '{16'h8000, 16'h7000, 0,     2, 1,  16'd1, 1'b1, 8'd2,  0};
        tbl[6] = '{16'hf0f0, 16'h7000, 0,     2, 1,  16'd1, 1'b1, 8'd2,  0};
        tbl[7] = '{16'h9000, 16'h0321, 0,     3, 1,  16'd2, 1'b1, 8'd3,  1};
        tbl[8] = '{16'h5105, 16'h7000, ACK_T, 0, 0,  16'd0, 1'b1, 8'd0,  0};
        exp_tr = '{3'b100, 3'b010, 3'b000, 3'b001, 3'b100};

        for (int i = 0; i < 9; i++) begin
            load_default();
            mem[0] = tbl[i].m0;
            mem[1] = tbl[i].m1;
            dly[0] = tbl[i].d0;
            run(64, 1'b0);
            chk("tbl_n_fetch", got_addr.size(), tbl[i].n);
            if (tbl[i].n > 1 && got_addr.size() > 1) chk("tbl_addr1", got_addr[1], tbl[i].a1);
            chk("tbl_halted", halted, 1'b1);
            chk("tbl_retired", retired, tbl[i].ret);
            chk("tbl_fault", fault, tbl[i].flt);
            chk("tbl_pc", pc, tbl[i].pc);
            chk("tbl_rf_we", got_we, tbl[i].we);
            chk("tbl_exclusive", excl_bad, 0);
            halt_start();
        end

        load_default();
        mem[0] = 16'h5105;
        run(64, 1'b0);
        for (int i = 0; i < 5 && i < trace.size(); i++) chk("loadi_strobes", trace[i], exp_tr[i]);
        chk("loadi_trace_len", trace.size() >= 5, 1'b1);
        if (dec_inst.size() > 0) chk("loadi_inst", dec_inst[0], 16'h5105);
        else chk("loadi_dec_seen", dec_inst.size(), 1);

        load_default();
        mem[0] = 16'h60FF;
        mem[255] = 16'h0123;
        model(3);
        run(3, 1'b0);
        check_model();
        if (got_addr.size() == 3) begin
            chk("wrap_addr_ff", got_addr[1], 8'hFF);
            chk("wrap_addr_00", got_addr[2], 8'h00);
        end

        for (int r = 0; r < 40; r++) begin
            load_default();
            for (int i = 0; i < 32; i++) begin
                ins = 16'($urandom);
                if (ins[15:12] == 4'd6) ins[7:0] = 8'(i + 1 + $urandom_range(0, 8));
                mem[i] = ins;
            end
            for (int i = 0; i < 64; i++) dly[i] = ($urandom_range(0, 9) == 0) ? ACK_T : $urandom_range(0, 3);
            model(64);
            run(64, 1'b1);
            check_model();
        end

        load_default();
        mem[0] = 16'h6020;
        res_n = 1'b0; start = 1'b0; imem_ack = 1'b0;
        repeat (2) @(negedge ck);
        chk("rst_ctl", {busy, imem_req, dec_en, rf_we, halted, fault}, 6'b0);
        chk("rst_pc", pc, 8'd0);
        chk("rst_retired", retired, 16'd0);
        res_n = 1'b1; start = 1'b1;
        @(negedge ck);
        start = 1'b0; imem_ack = 1'b1; imem_data = mem[0];
        @(negedge ck);
        imem_ack = 1'b0;
        repeat (2) @(negedge ck);
        chk("jmp_refetch", {imem_req, imem_addr}, {1'b1, 8'h20});
        chk("jmp_retired", retired, 16'd1);
        res_n = 1'b0; imem_ack = 1'b1; imem_data = 16'h5105; start = 1'b1;
        @(negedge ck);
        chk("midfetch_rst_ctl", {busy, imem_req, halted, fault}, 4'b0);
        chk("midfetch_rst_pc", pc, 8'd0);
        chk("midfetch_rst_inst", inst, 16'd0);
        chk("midfetch_rst_retired", retired, 16'd0);
        res_n = 1'b1; imem_ack = 1'b0; start = 1'b0;
        repeat (2) @(negedge ck);
        chk("idle_hold", {busy, imem_req}, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
